vdp_dma_master: RTL

VDP_DMA_MASTER -- requirements
Module: vdp_dma_master

---
 rtl/vdp_dma_pkg.sv | 17 +
 rtl/vdp_dma_master.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vdp_dma_pkg.sv
// Shared definitions for the VDP DMA master: FSM encoding and VDP command codes.
package vdp_dma_pkg;

  typedef enum logic [2:0] {
    IDLE, CTRL_LO, CTRL_HI, FETCH, WR, WR_DONE, GAP, FIN
  } dma_state_e;

  localparam logic [1:0] CODE_VRAM_WR = 2'd1;
  localparam logic [1:0] CODE_REG_WR  = 2'd2;
  localparam logic [1:0] CODE_CRAM_WR = 2'd3;

  // Only palette writes are honoured; every other code becomes a VRAM write.
  function automatic logic [1:0] norm_code(input logic [1:0] c);
    return (c == CODE_CRAM_WR) ? CODE_CRAM_WR : CODE_VRAM_WR;
  endfunction

endpackage

// File: rtl/vdp_dma_master.sv
// System-memory to VDP DMA: writes the two-byte control word, then streams
// bytes to the data port with a configurable idle gap between writes.
module vdp_dma_master
  import vdp_dma_pkg::*;
#(
  parameter int MIN_GAP = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_src_addr,
  input  logic [13:0] cfg_vram_addr,
  input  logic [1:0]  cfg_code,
  input  logic [13:0] cfg_len,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic        mem_rd_req,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rddata,
  output logic        io_portsel,
  output logic [7:0]  io_wrdata,
  output logic        io_wren,
  output logic        io_wrdone,
  output logic        io_rddone
);

  dma_state_e  state_q, state_d;
  logic        ph_q, ph_d;
  logic        abort_pend_q, abort_pend_d;
  logic [15:0] src_q, src_d;
  logic [13:0] vram_q, vram_d;
  logic [1:0]  code_q, code_d;
  logic [13:0] rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_req_q, mem_rd_req_d;
  logic        io_portsel_q, io_portsel_d;
  logic [7:0]  io_wrdata_q, io_wrdata_d;
  logic        io_wren_q, io_wren_d;
  logic        io_wrdone_q, io_wrdone_d;

  // Outputs are computed for the next state and registered, so each
  // strobe is high exactly in the cycle its state is occupied.
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    abort_pend_d = abort_pend_q;
    src_d        = src_q;
    vram_d       = vram_q;
    code_d       = code_q;
    rem_d        = rem_q;
    gap_d        = gap_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_rd_req_d = mem_rd_req_q;
    io_portsel_d = io_portsel_q;
    io_wrdata_d  = io_wrdata_q;
    io_wren_d    = 1'b0;
    io_wrdone_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (start) begin
          busy_d = 1'b1;
          if (cfg_len != 14'd0) begin
            src_d        = cfg_src_addr;
            vram_d       = cfg_vram_addr;
            code_d       = norm_code(cfg_code);
            rem_d        = cfg_len;
            state_d      = CTRL_LO;
            ph_d         = 1'b0;
            io_portsel_d = 1'b1;
            io_wrdata_d  = cfg_vram_addr[7:0];
            io_wren_d    = 1'b1;
          end else begin
            state_d = FIN;
          end
        end
      end
      // ph_q=0: io_wren is high now; ph_q=1: io_wrdone is high now.
      CTRL_LO, CTRL_HI: begin
        if (!ph_q) begin
          io_wrdone_d = 1'b1;
          ph_d        = 1'b1;
          if (abort) abort_pend_d = 1'b1;
        end else if (abort || abort_pend_q) begin
          state_d = FIN;
        end else if (state_q == CTRL_LO) begin
          state_d     = CTRL_HI;
          ph_d        = 1'b0;
          io_wrdata_d = {code_q, vram_q[13:8]};
          io_wren_d   = 1'b1;
        end else begin
          state_d      = FETCH;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = src_q;
        end
      end
      FETCH: begin
        if (abort) begin
          mem_rd_req_d = 1'b0;
          state_d      = FIN;
        end else if (mem_rd_ack) begin
          mem_rd_req_d = 1'b0;
          state_d      = WR;
          io_portsel_d = 1'b0;
          io_wrdata_d  = mem_rddata;
          io_wren_d    = 1'b1;
        end
      end
      WR: begin
        io_wrdone_d = 1'b1;
        state_d     = WR_DONE;
        if (abort) abort_pend_d = 1'b1;
      end
      WR_DONE: begin
        src_d = src_q + 16'd1;
        rem_d = rem_q - 14'd1;
        if (rem_q == 14'd1 || abort || abort_pend_q) begin
          state_d = FIN;
        end else if (MIN_GAP == 0) begin
          state_d      = FETCH;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = src_q + 16'd1;
        end else begin
          state_d = GAP;
          gap_d   = 4'(MIN_GAP - 1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d = FIN;
        end else if (gap_q == 4'd0) begin
          state_d      = FETCH;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = src_q;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      FIN: begin
        done_d       = 1'b1;
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ph_q         <= 1'b0;
      abort_pend_q <= 1'b0;
      src_q        <= '0;
      vram_q       <= '0;
      code_q       <= '0;
      rem_q        <= '0;
      gap_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_rd_req_q <= 1'b0;
      io_portsel_q <= 1'b0;
      io_wrdata_q  <= '0;
      io_wren_q    <= 1'b0;
      io_wrdone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      abort_pend_q <= abort_pend_d;
      src_q        <= src_d;
      vram_q       <= vram_d;
      code_q       <= code_d;
      rem_q        <= rem_d;
      gap_q        <= gap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mem_addr_q   <= mem_addr_d;
      mem_rd_req_q <= mem_rd_req_d;
      io_portsel_q <= io_portsel_d;
      io_wrdata_q  <= io_wrdata_d;
      io_wren_q    <= io_wren_d;
      io_wrdone_q  <= io_wrdone_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_req = mem_rd_req_q;
  assign io_portsel = io_portsel_q;
  assign io_wrdata  = io_wrdata_q;
  assign io_wren    = io_wren_q;
  assign io_wrdone  = io_wrdone_q;
  assign io_rddone  = 1'b0;

endmodule
